// File: rtl/ysyx_25040129_wb_arbiter_if.sv
// Bundle of the issue, write-back request and register-file write signals
// around the write-back arbiter.
//   master : issue stage / EXU / LSU / register-file side (drives requests,
//            observes readies, rf write port, scoreboard and error flag)
//   slave  : the arbiter itself
interface ysyx_25040129_wb_arbiter_if #(
    parameter int unsigned REGS_DIG = 5,
    parameter int unsigned XLEN     = 32
);
    localparam int unsigned NUM_REGS = 1 << REGS_DIG;

    // issue stage
    logic                iss_valid;
    logic                iss_ready;
    logic                iss_wen;
    logic [REGS_DIG-1:0] iss_rd;
    logic [REGS_DIG-1:0] iss_src1;
    logic [REGS_DIG-1:0] iss_src2;

    // EXU write-back request
    logic                exu_valid;
    logic                exu_ready;
    logic [REGS_DIG-1:0] exu_rd;
    logic [XLEN-1:0]     exu_data;

    // LSU write-back request
    logic                lsu_valid;
    logic                lsu_ready;
    logic [REGS_DIG-1:0] lsu_rd;
    logic [XLEN-1:0]     lsu_data;

    // register file write port and status
    logic                rf_wen;
    logic [REGS_DIG-1:0] rf_rd;
    logic [XLEN-1:0]     rf_wdata;
    logic [NUM_REGS-1:0] busy;
    logic                err;

    modport master (
        output iss_valid, iss_wen, iss_rd, iss_src1, iss_src2,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, exu_ready, lsu_ready,
        input  rf_wen, rf_rd, rf_wdata, busy, err
    );

    modport slave (
        input  iss_valid, iss_wen, iss_rd, iss_src1, iss_src2,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_ready, exu_ready, lsu_ready,
        output rf_wen, rf_rd, rf_wdata, busy, err
    );
endinterface

// File: rtl/ysyx_25040129_wb_arbiter.sv
// Write-back scheduler: round-robin arbitration of the single register-file
// write port between EXU and LSU, plus a per-register busy scoreboard that
// holds issue on RAW/WAW hazards.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : issue handshake (iss_*), EXU/LSU write-back requests (exu_*/lsu_*),
//          registered rf write port (rf_wen/rf_rd/rf_wdata), busy, sticky err.
//          iss_ready/exu_ready/lsu_ready are combinational.
module ysyx_25040129_wb_arbiter #(
    parameter int unsigned REGS_DIG = 5,
    parameter int unsigned XLEN     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_25040129_wb_arbiter_if.slave       bus
);
    localparam int unsigned NUM_REGS = 1 << REGS_DIG;

    // Which requester received the most recent grant.
    typedef enum logic {
        LAST_EXU = 1'b0,
        LAST_LSU = 1'b1
    } last_e;

    last_e               last_q,     last_d;
    logic [NUM_REGS-1:0] busy_q,     busy_d;
    logic                rf_wen_q,   rf_wen_d;
    logic [REGS_DIG-1:0] rf_rd_q,    rf_rd_d;
    logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
    logic                err_q,      err_d;

    logic                iss_ready_c;
    logic                grant_exu_c;
    logic                grant_lsu_c;
    logic [REGS_DIG-1:0] wb_rd_c;
    logic [XLEN-1:0]     wb_data_c;
    logic [NUM_REGS-1:0] set_mask_c;
    logic [NUM_REGS-1:0] clr_mask_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= LAST_LSU;
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            last_q     <= last_d;
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    // Hazard check, arbitration and next-state.
    always_comb begin
        last_d      = last_q;
        rf_wen_d    = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        err_d       = err_q;
        set_mask_c  = '0;
        clr_mask_c  = '0;

        // busy_q[0] is always 0, so x0 never causes a stall.
        iss_ready_c = !(busy_q[bus.iss_src1] | busy_q[bus.iss_src2] |
                        (bus.iss_wen & busy_q[bus.iss_rd]));

        // On a tie the requester that was not granted last wins.
        grant_exu_c = bus.exu_valid & (!bus.lsu_valid | (last_q == LAST_LSU));
        grant_lsu_c = bus.lsu_valid & (!bus.exu_valid | (last_q == LAST_EXU));

        wb_rd_c   = grant_lsu_c ? bus.lsu_rd   : bus.exu_rd;
        wb_data_c = grant_lsu_c ? bus.lsu_data : bus.exu_data;

        if (grant_exu_c) begin
            last_d = LAST_EXU;
        end else if (grant_lsu_c) begin
            last_d = LAST_LSU;
        end

        if (grant_exu_c | grant_lsu_c) begin
            rf_wen_d   = (wb_rd_c != '0);
            rf_rd_d    = wb_rd_c;
            rf_wdata_d = wb_data_c;
        end

        // Writing a register nobody is waiting on indicates a protocol bug.
        err_d = err_q | (rf_wen_d & ~busy_q[wb_rd_c]);

        // The write currently on the rf port retires its scoreboard entry.
        if (rf_wen_q) begin
            clr_mask_c[rf_rd_q] = 1'b1;
        end
        if (bus.iss_valid & iss_ready_c & bus.iss_wen & (bus.iss_rd != '0)) begin
            set_mask_c[bus.iss_rd] = 1'b1;
        end

        // Set wins over clear on the same index.
        busy_d    = (busy_q & ~clr_mask_c) | set_mask_c;
        busy_d[0] = 1'b0;
    end

    assign bus.iss_ready = iss_ready_c;
    assign bus.exu_ready = grant_exu_c;
    assign bus.lsu_ready = grant_lsu_c;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ysyx_25040129_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus a randomized run,
// all compared against a behavioural model of the scoreboard and arbiter.
module tb_ysyx_25040129_wb_arbiter;
    logic clk;
    logic rst;

    ysyx_25040129_wb_arbiter_if bus ();

    ysyx_25040129_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural model ----------------
    bit          m_busy [32];
    bit          m_last_exu;   // 1: most recent grant went to EXU
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;
    bit          m_err;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_last_exu = 1'b0;
        m_wen      = 1'b0;
        m_rd       = '0;
        m_wdata    = '0;
        m_err      = 1'b0;
    endtask

    function automatic bit exp_iss_ready();
        return !(m_busy[bus.iss_src1] || m_busy[bus.iss_src2] ||
                 (bus.iss_wen && m_busy[bus.iss_rd]));
    endfunction

    function automatic bit exp_exu_grant();
        if (!bus.exu_valid) return 1'b0;
        if (!bus.lsu_valid) return 1'b1;
        return !m_last_exu;
    endfunction

    function automatic bit exp_lsu_grant();
        if (!bus.lsu_valid) return 1'b0;
        if (!bus.exu_valid) return 1'b1;
        return m_last_exu;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Apply one clock edge to the model using the current inputs, then
    // advance the simulation to just after that edge.
    task automatic model_clock();
        bit          ge, gl, fire, nwen;
        logic [4:0]  rd;
        logic [31:0] d;
        ge   = exp_exu_grant();
        gl   = exp_lsu_grant();
        fire = bus.iss_valid && exp_iss_ready() && bus.iss_wen && (bus.iss_rd != 5'd0);
        rd   = ge ? bus.exu_rd   : bus.lsu_rd;
        d    = ge ? bus.exu_data : bus.lsu_data;
        if (ge || gl) m_last_exu = ge;
        nwen = (ge || gl) && (rd != 5'd0);
        if (nwen && !m_busy[rd]) m_err = 1'b1;
        if (m_wen) m_busy[m_rd] = 1'b0;
        if (fire) m_busy[bus.iss_rd] = 1'b1;
        m_wen = nwen;
        if (nwen) begin
            m_rd    = rd;
            m_wdata = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iss_valid = 1'b0; bus.iss_wen  = 1'b0;
        bus.iss_rd    = '0;   bus.iss_src1 = '0; bus.iss_src2 = '0;
        bus.exu_valid = 1'b0; bus.exu_rd   = '0; bus.exu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd   = '0; bus.lsu_data = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 32'h0) begin n_errors++; $display("FAIL reset_busy: got %h expected 00000000", bus.busy); end
        n_checks++;
        if (bus.rf_wen !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_rf: got wen=%b rd=%0d data=%h expected 0/0/0", bus.rf_wen, bus.rf_rd, bus.rf_wdata);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_scoreboard();
        bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd5;
        bus.iss_src1 = 5'd0; bus.iss_src2 = 5'd0;
        #1;
        n_checks++;
        if (bus.iss_ready !== 1'b1) begin n_errors++; $display("FAIL sb_first_issue_ready: got %b expected 1", bus.iss_ready); end
        model_clock();
        bus.iss_valid = 1'b1; bus.iss_wen = 1'b0; bus.iss_rd = 5'd0; bus.iss_src1 = 5'd5;
        #1;
        n_checks++;
        if (bus.busy !== 32'h20 || exp_busy() !== 32'h20) begin
            n_errors++; $display("FAIL sb_busy_set: got %h expected 00000020", bus.busy);
        end
        n_checks++;
        if (bus.iss_ready !== 1'b0) begin n_errors++; $display("FAIL sb_raw_stall: got %b expected 0", bus.iss_ready); end
        bus.iss_src1 = 5'd0; bus.iss_src2 = 5'd5;
        #1;
        n_checks++;
        if (bus.iss_ready !== 1'b0) begin n_errors++; $display("FAIL sb_raw_stall_src2: got %b expected 0", bus.iss_ready); end
        bus.iss_src2 = 5'd0; bus.iss_wen = 1'b1; bus.iss_rd = 5'd5;
        #1;
        n_checks++;
        if (bus.iss_ready !== 1'b0) begin n_errors++; $display("FAIL sb_waw_stall: got %b expected 0", bus.iss_ready); end
        bus.iss_valid = 1'b0; bus.iss_wen = 1'b0; bus.iss_rd = 5'd0;
    endtask

    task automatic test_writeback();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (bus.exu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            n_errors++; $display("FAIL wb_grant: got exu=%b lsu=%b expected 1/0", bus.exu_ready, bus.lsu_ready);
        end
        model_clock();
        bus.exu_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_src1 = 5'd5;
        #1;
        n_checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL wb_rf_port: got wen=%b rd=%0d data=%h expected 1/5/deadbeef", bus.rf_wen, bus.rf_rd, bus.rf_wdata);
        end
        n_checks++;
        if (bus.iss_ready !== 1'b0) begin n_errors++; $display("FAIL wb_still_busy: got %b expected 0", bus.iss_ready); end
        model_clock();
        #1;
        n_checks++;
        if (bus.busy[5] !== 1'b0 || bus.iss_ready !== 1'b1 || bus.rf_wen !== 1'b0) begin
            n_errors++; $display("FAIL wb_dep_ready: got busy5=%b ready=%b wen=%b expected 0/1/0", bus.busy[5], bus.iss_ready, bus.rf_wen);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin n_errors++; $display("FAIL wb_err: got %b expected 0", bus.err); end
        bus.iss_valid = 1'b0; bus.iss_src1 = 5'd0;
    endtask

    task automatic test_rd_zero();
        logic [31:0] busy_before;
        bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd9;
        model_clock();
        bus.iss_valid = 1'b0; bus.iss_wen = 1'b0; bus.iss_rd = 5'd0;
        busy_before = exp_busy();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'h1234;
        #1;
        n_checks++;
        if (bus.exu_ready !== 1'b1) begin n_errors++; $display("FAIL rd0_ready: got %b expected 1", bus.exu_ready); end
        model_clock();
        bus.exu_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.rf_wen !== 1'b0) begin n_errors++; $display("FAIL rd0_wen: got %b expected 0", bus.rf_wen); end
        n_checks++;
        if (bus.busy !== busy_before || bus.busy !== 32'h200) begin
            n_errors++; $display("FAIL rd0_busy: got %h expected %h", bus.busy, busy_before);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin n_errors++; $display("FAIL rd0_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_err();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = $urandom;
        #1;
        n_checks++;
        if (bus.lsu_ready !== 1'b1) begin n_errors++; $display("FAIL err_grant: got %b expected 1", bus.lsu_ready); end
        model_clock();
        bus.lsu_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== m_wdata) begin
            n_errors++; $display("FAIL err_write: got wen=%b rd=%0d data=%h expected 1/7/%h", bus.rf_wen, bus.rf_rd, bus.rf_wdata, m_wdata);
        end
        n_checks++;
        if (bus.err !== 1'b1) begin n_errors++; $display("FAIL err_set: got %b expected 1", bus.err); end
        repeat (3) model_clock();
        n_checks++;
        if (bus.err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
    endtask

    task automatic test_contention();
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd1; bus.exu_data = 32'h1111_0001;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            bit want_exu;
            want_exu = (i % 2 == 0);
            #1;
            n_checks++;
            if (bus.exu_ready !== want_exu || bus.lsu_ready !== !want_exu) begin
                n_errors++; $display("FAIL rr_order[%0d]: got exu=%b lsu=%b expected %b/%b", i, bus.exu_ready, bus.lsu_ready, want_exu, !want_exu);
            end
            model_clock();
            n_checks++;
            if (bus.rf_wen !== 1'b1 || bus.rf_rd !== (want_exu ? 5'd1 : 5'd2)) begin
                n_errors++; $display("FAIL rr_write[%0d]: got wen=%b rd=%0d expected 1/%0d", i, bus.rf_wen, bus.rf_rd, want_exu ? 1 : 2);
            end
        end
        bus.exu_valid = 1'b0; bus.lsu_valid = 1'b0;
    endtask

    task automatic test_random();
        bit exu_pend, lsu_pend, ge, gl;
        exu_pend = 1'b0; lsu_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!exu_pend && $urandom_range(0, 1) == 1) begin
                exu_pend = 1'b1; bus.exu_rd = 5'($urandom_range(0, 7)); bus.exu_data = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 1) == 1) begin
                lsu_pend = 1'b1; bus.lsu_rd = 5'($urandom_range(0, 7)); bus.lsu_data = $urandom;
            end
            bus.exu_valid = exu_pend;
            bus.lsu_valid = lsu_pend;
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_wen   = 1'($urandom_range(0, 1));
            bus.iss_rd    = 5'($urandom_range(0, 7));
            bus.iss_src1  = 5'($urandom_range(0, 7));
            bus.iss_src2  = 5'($urandom_range(0, 7));
            #1;
            ge = exp_exu_grant();
            gl = exp_lsu_grant();
            n_checks++;
            if (bus.iss_ready !== exp_iss_ready() || bus.exu_ready !== ge || bus.lsu_ready !== gl) begin
                n_errors++; $display("FAIL rand_ready[%0d]: got iss=%b exu=%b lsu=%b expected %b/%b/%b",
                    c, bus.iss_ready, bus.exu_ready, bus.lsu_ready, exp_iss_ready(), ge, gl);
            end
            if (ge) exu_pend = 1'b0;
            if (gl) lsu_pend = 1'b0;
            model_clock();
            n_checks++;
            if (bus.rf_wen !== m_wen || (m_wen && (bus.rf_rd !== m_rd || bus.rf_wdata !== m_wdata))) begin
                n_errors++; $display("FAIL rand_rf[%0d]: got wen=%b rd=%0d data=%h expected %b/%0d/%h",
                    c, bus.rf_wen, bus.rf_rd, bus.rf_wdata, m_wen, m_rd, m_wdata);
            end
            n_checks++;
            if (bus.busy !== exp_busy() || bus.err !== m_err) begin
                n_errors++; $display("FAIL rand_state[%0d]: got busy=%h err=%b expected %h/%b", c, bus.busy, bus.err, exp_busy(), m_err);
            end
        end
        idle_inputs();
        repeat (2) model_clock();
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 32; i++) begin
            if (!m_busy[i]) begin
                bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'(i);
                bus.iss_src1 = 5'd0; bus.iss_src2 = 5'd0;
                model_clock();
            end
        end
        idle_inputs();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 32'hCAFE_0003;
        #1;
        n_checks++;
        if (bus.busy !== 32'hFFFFFFFE || bus.exu_ready !== 1'b1) begin
            n_errors++; $display("FAIL ar_full: got busy=%h ready=%b expected fffffffe/1", bus.busy, bus.exu_ready);
        end
        model_clock();
        bus.exu_valid = 1'b0;
        n_checks++;
        if (bus.rf_wen !== 1'b1 || bus.busy !== 32'hFFFFFFFE) begin
            n_errors++; $display("FAIL ar_inflight: got wen=%b busy=%h expected 1/fffffffe", bus.rf_wen, bus.busy);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.busy !== 32'h0 || bus.rf_wen !== 1'b0 || bus.err !== 1'b0) begin
            n_errors++; $display("FAIL ar_immediate: got busy=%h wen=%b err=%b expected 0/0/0", bus.busy, bus.rf_wen, bus.err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd1; bus.exu_data = 32'hA;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'hB;
        #1;
        n_checks++;
        if (bus.exu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
            n_errors++; $display("FAIL ar_first_tie: got exu=%b lsu=%b expected 1/0", bus.exu_ready, bus.lsu_ready);
        end
        model_clock();
        idle_inputs();
        n_checks++;
        if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd1 || bus.rf_wdata !== 32'hA) begin
            n_errors++; $display("FAIL ar_first_write: got wen=%b rd=%0d data=%h expected 1/1/0000000a", bus.rf_wen, bus.rf_rd, bus.rf_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_scoreboard();
        test_writeback();
        test_rd_zero();
        test_err();
        test_contention();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_wb_arbiter.md
# ysyx_25040129_wb_arbiter

Write-back scheduler for the 31×32-bit architectural register file: shares its single write port between the execute unit (EXU) and the load/store unit (LSU) with round-robin arbitration. It also keeps a per-register busy scoreboard that stalls instruction issue on RAW/WAW hazards. It sits between issue/EXU/LSU and the register file's `reg_write`/`rd`/`result` inputs.

## Interface
- `REGS_DIG`, 5, register index width (32 registers, x0 hard-wired zero)
- `XLEN`, 32, data width
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `iss_valid`  in  1  issue stage presents an instruction
- `iss_ready`  out  1  no hazard; instruction may issue (fire = valid & ready)
- `iss_wen`  in  1  instruction writes a destination register
- `iss_rd`, `iss_src1`, `iss_src2`  in  REGS_DIG  destination / source indices
- `exu_valid`  in  1  EXU write-back request
- `exu_ready`  out  1  EXU request granted this cycle
- `exu_rd`  in  REGS_DIG;  `exu_data`  in  XLEN
- `lsu_valid`  in  1  LSU write-back request
- `lsu_ready`  out  1  LSU request granted this cycle
- `lsu_rd`  in  REGS_DIG;  `lsu_data`  in  XLEN
- `rf_wen`  out  1  register file write enable (to `reg_write`)
- `rf_rd`  out  REGS_DIG;  `rf_wdata`  out  XLEN  (to `rd` / `result`)
- `busy`  out  32  scoreboard bits; bit 0 constant 0
- `err`  out  1  sticky: write-back to a non-busy nonzero register

## Operation
- Scoreboard: `busy[i]` set on issue fire with `iss_wen=1`, `iss_rd=i`, i≠0; cleared on the edge where `rf_wen=1`, `rf_rd=i`. Set has priority on same index (unreachable in legal use).
- `iss_ready = !(busy[iss_src1] | busy[iss_src2] | (iss_wen & busy[iss_rd]))`; index 0 never busy. `iss_ready` does not depend on `iss_valid`.
- Arbiter: one grant per cycle. Only one requester valid → grant it. Both valid → grant the one not granted last. Pointer `last` updates only on a grant. Neither valid → no grant, `last` holds.
- `exu_ready`/`lsu_ready` are the grant signals. A requester holds valid/rd/data stable until granted. A requester may not drop valid before grant.
- On grant: next cycle `rf_wen=1`, `rf_rd` = granted rd, `rf_wdata` = granted data. No grant: `rf_wen=0`; `rf_rd`/`rf_wdata` hold.
- Grant with rd=0: accepted (ready=1). Next cycle `rf_wen=0`, scoreboard unchanged, `err` unaffected.
- Grant with rd≠0 and `busy[rd]=0`: write still performed, `err` set and held until reset.
- Reset (any cycle, asynchronous): `busy`=0, `rf_wen`=0, `rf_rd`=0, `rf_wdata`=0, `err`=0, `last`=LSU (EXU wins first tie). A write in flight at reset is dropped.

## Timing
- `iss_ready`, `exu_ready`, `lsu_ready` are combinational from current inputs and state; no combinational path from ready to valid.
- Write-back latency: grant at cycle N → `rf_wen` high during N+1 → register file updated at end of N+1.
- Busy clear happens on that same edge. A dependent instruction sees `iss_ready=1` in cycle N+2 and reads the new value from the register file.
- Issue fire at cycle N → `busy[rd]` visible from N+1.
- Back-to-back grants sustain one write per cycle. Under continuous dual contention, grants alternate EXU, LSU, EXU, …
- Grant and busy-set to the same register in the same cycle cannot occur: the WAW check stalls issue.

## Test plan
- Reset then issue `iss_rd=5`, `iss_wen=1` → `busy=0x20` next cycle. Issue with `iss_src1=5` → `iss_ready=0`.
- EXU writes rd=5, data 0xDEADBEEF, grant at N → N+1: `rf_wen=1`, `rf_rd=5`, `rf_wdata=0xDEADBEEF`. N+2: `busy[5]=0`, dependent `iss_ready=1`.
- EXU and LSU valid for 4 cycles after reset, rds 1/2 → grant order EXU, LSU, EXU, LSU. Exactly one ready per cycle.
- Write-back rd=0, data 0x1234 → ready=1, `rf_wen` stays 0, `busy` and `err` unchanged.
- LSU writes rd=7 while `busy[7]=0` → write performed, `err=1` and held until `rst` low.
- Assert `rst` low mid-cycle with `busy=0xFFFFFFFE` and a grant pending → immediately `busy=0`, `rf_wen=0`, `err=0`. After release, first tie grants EXU.
